// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding memory request FSM, static
// branch prediction on returned words, and a two-entry instruction buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        pred_taken_o
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] buf_inst [2];
    logic [31:0] buf_pc   [2];
    logic        buf_pred [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        req;
    logic        accept;
    logic        pop;
    logic [1:0]  branch_jump_op;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic [31:0] redirect_target;

    assign req             = !rst_i && (state == ISSUE) && (count < DEPTH);
    assign accept          = (state == WAIT_RSP) && imem_rvalid_i && !redirect_i;
    assign pop             = inst_valid_o && inst_ready_i;
    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

    // Classify the returned word by opcode bits [6:2]
    always_comb begin
        branch_jump_op = 2'b00;
        case (imem_rdata_i[6:2])
            5'b11011: branch_jump_op = 2'b01;
            5'b11001: branch_jump_op = 2'b01;
            5'b11000: branch_jump_op = 2'b10;
            default:  branch_jump_op = 2'b00;
        endcase
    end

    // Static prediction: JAL always taken, backward branches taken, else sequential
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = fetch_pc + 32'd4;
        case (branch_jump_op)
            2'b01: begin
                if (imem_rdata_i[3]) begin
                    pred_taken = 1'b1;
                    next_pc    = fetch_pc + j_imm(imem_rdata_i);
                end else begin
                    pred_taken = 1'b0;
                    next_pc    = fetch_pc + 32'd4;
                end
            end
            2'b10: begin
                if (imem_rdata_i[31]) begin
                    pred_taken = 1'b1;
                    next_pc    = fetch_pc + b_imm(imem_rdata_i);
                end else begin
                    pred_taken = 1'b0;
                    next_pc    = fetch_pc + 32'd4;
                end
            end
            default: begin
                pred_taken = 1'b0;
                next_pc    = fetch_pc + 32'd4;
            end
        endcase
    end

    // Request FSM and fetch PC; fetch_pc stays at the outstanding address until answered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ISSUE;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                ISSUE: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_target;
                        state    <= (req && imem_gnt_i) ? DRAIN : ISSUE;
                    end else if (req && imem_gnt_i) begin
                        state <= WAIT_RSP;
                    end else begin
                        state <= ISSUE;
                    end
                end
                WAIT_RSP: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_target;
                        state    <= imem_rvalid_i ? ISSUE : DRAIN;
                    end else if (imem_rvalid_i) begin
                        fetch_pc <= next_pc;
                        state    <= ISSUE;
                    end else begin
                        state <= WAIT_RSP;
                    end
                end
                DRAIN: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_target;
                    end else begin
                        fetch_pc <= fetch_pc;
                    end
                    state <= imem_rvalid_i ? ISSUE : DRAIN;
                end
                default: begin
                    state <= ISSUE;
                end
            endcase
        end
    end

    // Instruction buffer; a redirect flushes it and overrides any push or pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_inst[i] <= 32'h0000_0000;
                buf_pc[i]   <= 32'h0000_0000;
                buf_pred[i] <= 1'b0;
            end
        end else if (redirect_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) begin
                buf_inst[wr_ptr] <= imem_rdata_i;
                buf_pc[wr_ptr]   <= fetch_pc;
                buf_pred[wr_ptr] <= pred_taken;
                wr_ptr           <= ~wr_ptr;
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end else begin
                rd_ptr <= rd_ptr;
            end
            count <= count + (accept ? 2'd1 : 2'd0) - (pop ? 2'd1 : 2'd0);
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc;
    assign inst_valid_o = (count != 2'd0);
    assign inst_o       = inst_valid_o ? buf_inst[rd_ptr] : 32'h0000_0000;
    assign pc_o         = inst_valid_o ? buf_pc[rd_ptr]   : 32'h0000_0000;
    assign pred_taken_o = inst_valid_o ? buf_pred[rd_ptr] : 1'b0;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, default 2, instruction buffer entries (fixed at 2; other values unsupported).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 imem_req_o  output  1  fetch request valid.
REQ-006 imem_addr_o  output  32  fetch address, word aligned ([1:0]=00).
REQ-007 imem_gnt_i  input  1  memory accepts request this cycle.
REQ-008 imem_rvalid_i  input  1  response data valid.
REQ-009 imem_rdata_i  input  32  fetched instruction word.
REQ-010 redirect_i  input  1  pipeline flush/redirect from execute.
REQ-011 redirect_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 00).
REQ-012 inst_valid_o  output  1  buffer head valid.
REQ-013 inst_ready_i  input  1  decode consumes head when inst_valid_o=1.
REQ-014 inst_o  output  32  head instruction.
REQ-015 pc_o  output  32  head instruction PC.
REQ-016 pred_taken_o  output  1  head was statically predicted taken.

Function
REQ-017 States: ISSUE (drive request), WAIT_RSP (granted, awaiting rvalid), DRAIN (granted request to discard).
REQ-018 At most one granted-but-unanswered request at any time.
REQ-019 ISSUE: imem_req_o=1 only when FIFO count + 0 outstanding < 2; imem_addr_o=fetch_pc.
REQ-020 imem_req_o and imem_addr_o held stable until imem_gnt_i=1, except on redirect.
REQ-021 ISSUE with req and gnt -> WAIT_RSP; rvalid in WAIT_RSP -> ISSUE, earliest next request 1 cycle after rvalid.
REQ-022 On accepted response, decode opcode bits [6:2]: branch_jump_op 01 = JAL(11011)/JALR(11001), 10 = BRANCH(11000), 00 otherwise.
REQ-023 JAL: pred_taken=1, next fetch_pc = pc + J-imm {sext inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-024 BRANCH: pred_taken = B-imm sign bit (inst[31]); if taken, next fetch_pc = pc + B-imm {sext inst[31], inst[7], inst[30:25], inst[11:8], 0}.
REQ-025 JALR and all others: pred_taken=0, next fetch_pc = pc + 4; 32-bit wrap-around, carry discarded.
REQ-026 Response pushes {inst, pc, pred_taken} into FIFO in the rvalid cycle; visible on outputs next cycle.
REQ-027 inst_valid_o = FIFO non-empty; pop when inst_valid_o & inst_ready_i; simultaneous push and pop allowed at count 1 and 2.
REQ-028 Request never issued while FIFO full; push into a full FIFO is impossible by REQ-019.
REQ-029 redirect_i: FIFO flushed (count=0), fetch_pc <= {redirect_pc_i[31:2],00}, inst_valid_o=0 next cycle.
REQ-030 Redirect in WAIT_RSP without rvalid, or in ISSUE with gnt same cycle -> DRAIN.
REQ-031 Redirect in WAIT_RSP with rvalid same cycle: response discarded, -> ISSUE.
REQ-032 Redirect in ISSUE without gnt: request withdrawn/readdressed, new address driven next cycle.
REQ-033 DRAIN: imem_req_o=0; next rvalid discarded, -> ISSUE; further redirects in DRAIN update fetch_pc only.
REQ-034 Redirect has priority over response push and prediction update in the same cycle.

Reset
REQ-035 While rst_i=1 (sampled): state ISSUE, fetch_pc=RESET_PC, FIFO empty, discard flag clear.
REQ-036 Outputs in cycle after reset edge: imem_req_o=0 during reset, inst_valid_o=0, pred_taken_o=0, inst_o/pc_o=0.
REQ-037 First request (addr RESET_PC) asserted in first cycle with rst_i=0; reset mid-transaction drops any pending response.

Verification
REQ-038 Reset, gnt=1, rvalid 1 cycle later with ADDI (0x00100093), ready=1 -> addresses 0x0, 0x4, 0x8; pc_o=0x0, pred_taken_o=0.
REQ-039 Fetch at 0x100 returns JAL x0,+0x20 (0x0200006F) -> next imem_addr_o=0x120, pred_taken_o=1.
REQ-040 Fetch at 0x200 returns BEQ offset -8 (0xFE000CE3) -> next addr 0x1F8, pred 1; BEQ +8 (0x00000463) -> next 0x204, pred 0.
REQ-041 inst_ready_i=0 for 10 cycles -> exactly 2 entries buffered, imem_req_o=0 until a pop.
REQ-042 Redirect to 0x403 in WAIT_RSP, rvalid 2 cycles later -> response dropped, inst_valid_o=0, next request addr 0x400.
REQ-043 Redirect and rvalid same cycle -> no push, next request addr = redirect target.
